// File: rtl/fifo_read_arbiter_if.sv
// Bundle of the FIFO read side and the requester side of the read arbiter.
// The master drives FIFO head and requester strobes; the slave is the arbiter.
interface fifo_read_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REQ_COUNT  = 4
);
  logic [DATA_WIDTH-1:0] iData;
  logic                  iEmpty;
  logic                  oReadEn;
  logic [REQ_COUNT-1:0]  iReq;
  logic [REQ_COUNT-1:0]  iAck;
  logic [REQ_COUNT-1:0]  oGrant;
  logic [REQ_COUNT-1:0]  oValid;
  logic [DATA_WIDTH-1:0] oData;
  logic                  oBusy;
  logic [15:0]           oDropCount;

  modport master (
    output iData, iEmpty, iReq, iAck,
    input  oReadEn, oGrant, oValid, oData, oBusy, oDropCount
  );

  modport slave (
    input  iData, iEmpty, iReq, iAck,
    output oReadEn, oGrant, oValid, oData, oBusy, oDropCount
  );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter that pops one FWFT FIFO word at a time and hands it to
// a single requester, dropping the word if it is not acked within a timeout.
module fifo_read_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_COUNT      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               iClk,
  input  logic               iResetN,
  fifo_read_arbiter_if.slave bus
);
  localparam int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]        CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]        LAST_INIT = IW'(REQ_COUNT - 1);
  localparam logic [REQ_COUNT-1:0] ONE_HOT0  = REQ_COUNT'(1);

  typedef enum logic {IDLE, DELIVER} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         gidx_q, gidx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [REQ_COUNT-1:0]  own_q, own_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           drop_q, drop_d;
  logic                  rd_q, rd_d;
  logic                  rdy_q;

  logic [IW-1:0] win_idx, scan_idx;
  logic          win_found;
  logic          ack_hit;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= REQ_COUNT; k++) begin
      scan_idx = IW'((int'(last_q) + k) % REQ_COUNT);
      if (!win_found && bus.iReq[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign ack_hit = |(bus.iAck & own_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    data_d  = data_q;
    drop_d  = drop_q;
    rd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // rdy_q holds off the first accept until the second edge after reset release.
        if (rdy_q && !bus.iEmpty && win_found) begin
          state_d = DELIVER;
          gidx_d  = win_idx;
          own_d   = ONE_HOT0 << win_idx;
          data_d  = bus.iData;
          cnt_d   = '0;
          rd_d    = 1'b1;
        end
      end
      DELIVER: begin
        if (ack_hit) begin
          state_d = IDLE;
          own_d   = '0;
          last_d  = gidx_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          own_d   = '0;
          last_d  = gidx_q;
          drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      state_q <= IDLE;
      last_q  <= LAST_INIT;
      gidx_q  <= '0;
      cnt_q   <= '0;
      own_q   <= '0;
      data_q  <= '0;
      drop_q  <= '0;
      rd_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      rd_q    <= rd_d;
      rdy_q   <= 1'b1;
    end
  end

  assign bus.oReadEn    = rd_q;
  assign bus.oGrant     = own_q;
  assign bus.oValid     = own_q;
  assign bus.oData      = data_q;
  assign bus.oBusy      = (state_q == DELIVER);
  assign bus.oDropCount = drop_q;
endmodule
